// File: rtl/crc8_pkg.sv
// crc8_pkg: shared CRC-8 constants, frame-checker FSM state and result payload.
// Imported by crc8_bit_step and crc8_frame_checker.
package crc8_pkg;

  localparam int unsigned CRC_W = 8;

  // Defaults must match the transmit-side generator.
  localparam logic [CRC_W-1:0] CRC_POLY_DEF = 8'h07;
  localparam logic [CRC_W-1:0] CRC_INIT_DEF = 8'h00;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } crc8_state_e;

  // Per-frame result; the frame length travels separately because its width is a parameter.
  typedef struct packed {
    logic             ok;
    logic             is_short;
    logic             abort;
    logic             overflow;
    logic [CRC_W-1:0] rx_crc;
  } crc8_res_t;

endpackage

// File: rtl/crc8_bit_step.sv
// crc8_bit_step: combinational single-bit CRC-8 update, MSB-first, shared with the generator.
// Ports:
//   crc_in  [CRC_W-1:0]  current CRC register
//   bit_in               serial data bit
//   crc_out [CRC_W-1:0]  CRC register after absorbing bit_in
module crc8_bit_step
  import crc8_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEF
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_out
);

  // Shift left, fold in the polynomial when the outgoing MSB differs from the data bit.
  always_comb begin
    crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ ((bit_in ^ crc_in[CRC_W-1]) ? POLY : '0);
  end

endmodule

// File: rtl/crc8_frame_checker.sv
// crc8_frame_checker: receive-side CRC-8 check of a bit-serial frame (payload then 8 CRC bits,
// MSB first). Reports residue pass/fail, short / abort / overflow flags, length and the
// received CRC field, one cycle after the frame's last beat.
// Optional build macro: CRC8_CHK_STATS_EN adds saturating good/bad result counters.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid                     qualifies in_bit / in_sof / in_eof
//   in_bit, in_sof, in_eof       serial bit, first-bit and last-bit markers
//   res_valid                    one-cycle pulse when the res_* fields update
//   res_ok                       residue zero and no short / abort / overflow
//   res_short                    fewer than CRC_W+1 bits
//   res_abort                    frame cut off by a new in_sof
//   res_overflow                 bit count saturated
//   res_len [LEN_W-1:0]          bits received, CRC bits included
//   res_rx_crc [CRC_W-1:0]       last CRC_W bits received
//   stat_good, stat_bad [15:0]   (CRC8_CHK_STATS_EN only) result tallies
module crc8_frame_checker
  import crc8_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY  = CRC_POLY_DEF,
  parameter logic [CRC_W-1:0] INIT  = CRC_INIT_DEF,
  parameter int unsigned      LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             res_valid,
  output logic             res_ok,
  output logic             res_short,
  output logic             res_abort,
  output logic             res_overflow,
  output logic [LEN_W-1:0] res_len,
  output logic [CRC_W-1:0] res_rx_crc
`ifdef CRC8_CHK_STATS_EN
  ,
  output logic [15:0]      stat_good,
  output logic [15:0]      stat_bad
`endif
);

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(CRC_W + 1);

  crc8_state_e      state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CRC_W-1:0] shreg_q, shreg_d;
  logic             ovf_q, ovf_d;

  logic             res_fire;
  crc8_res_t        res_d;
  logic [LEN_W-1:0] len_d;

  logic [CRC_W-1:0] step_src;
  logic [CRC_W-1:0] crc_step;
  logic [LEN_W-1:0] cnt_inc;
  logic             ovf_inc;
  logic [CRC_W-1:0] shreg_cont;
  logic [CRC_W-1:0] shreg_first;
  logic             end_short;

  // A start-of-frame beat always restarts from INIT, in either state.
  assign step_src    = in_sof ? INIT : crc_q;
  assign cnt_inc     = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + LEN_ONE;
  assign ovf_inc     = ovf_q | (cnt_inc == LEN_MAX);
  assign shreg_cont  = {shreg_q[CRC_W-2:0], in_bit};
  assign shreg_first = {{(CRC_W-1){1'b0}}, in_bit};
  assign end_short   = (cnt_inc < MIN_LEN);

  crc8_bit_step #(
    .POLY (POLY)
  ) u_step (
    .crc_in  (step_src),
    .bit_in  (in_bit),
    .crc_out (crc_step)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; sof+eof together in RECV drops the new 1-bit frame and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid && in_sof && !in_eof) state_d = RECV;
      RECV: if (in_valid && in_eof)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values and result formation.
  always_comb begin
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    ovf_d    = ovf_q;
    res_fire = 1'b0;
    res_d    = '0;
    len_d    = '0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_sof) begin
          crc_d   = crc_step;
          cnt_d   = LEN_ONE;
          shreg_d = shreg_first;
          ovf_d   = 1'b0;
          if (in_eof) begin
            res_fire       = 1'b1;
            res_d.is_short = 1'b1;
            res_d.rx_crc   = shreg_first;
            len_d          = LEN_ONE;
          end
        end
      end
      RECV: begin
        if (in_valid) begin
          if (in_sof) begin
            // Abort the open frame with what has arrived so far, then restart on this beat.
            res_fire       = 1'b1;
            res_d.abort    = 1'b1;
            res_d.is_short = (cnt_q < MIN_LEN);
            res_d.overflow = ovf_q;
            res_d.rx_crc   = shreg_q;
            len_d          = cnt_q;
            crc_d          = crc_step;
            cnt_d          = LEN_ONE;
            shreg_d        = shreg_first;
            ovf_d          = 1'b0;
          end else begin
            crc_d   = crc_step;
            cnt_d   = cnt_inc;
            shreg_d = shreg_cont;
            ovf_d   = ovf_inc;
            if (in_eof) begin
              // Good frames carry their own CRC, so the residue after the last bit is zero.
              res_fire       = 1'b1;
              res_d.is_short = end_short;
              res_d.overflow = ovf_inc;
              res_d.rx_crc   = shreg_cont;
              res_d.ok       = (crc_step == '0) && !end_short && !ovf_inc;
              len_d          = cnt_inc;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Frame datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q   <= INIT;
      cnt_q   <= '0;
      shreg_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result registers: fields hold until the next result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid    <= 1'b0;
      res_ok       <= 1'b0;
      res_short    <= 1'b0;
      res_abort    <= 1'b0;
      res_overflow <= 1'b0;
      res_len      <= '0;
      res_rx_crc   <= '0;
    end else begin
      res_valid <= res_fire;
      if (res_fire) begin
        res_ok       <= res_d.ok;
        res_short    <= res_d.is_short;
        res_abort    <= res_d.abort;
        res_overflow <= res_d.overflow;
        res_len      <= len_d;
        res_rx_crc   <= res_d.rx_crc;
      end
    end
  end

`ifdef CRC8_CHK_STATS_EN
  // Saturating result tallies, updated alongside the result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_good <= '0;
      stat_bad  <= '0;
    end else if (res_fire) begin
      if (res_d.ok) begin
        if (stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
      end else begin
        if (stat_bad != 16'hFFFF) stat_bad <= stat_bad + 16'd1;
      end
    end
  end
`endif

endmodule
